// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states and op classification.
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_MADD  = 4'd2;
    localparam logic [3:0] OP_MADDU = 4'd3;
    localparam logic [3:0] OP_MSUB  = 4'd4;
    localparam logic [3:0] OP_MSUBU = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_DIVU  = 4'd7;
    localparam logic [3:0] OP_MTHI  = 4'd8;
    localparam logic [3:0] OP_MTLO  = 4'd9;

    localparam logic [3:0] OP_ILLEGAL_MIN = 4'd10;

    // LO is filled with this bit on divide-by-zero
    localparam logic DIV0_LO_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIXUP,
        ST_FINISH
    } state_t;

    function automatic logic op_is_mul(input logic [3:0] op);
        return op <= OP_MSUBU;
    endfunction

    function automatic logic op_is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Even codes up to DIV are the signed variants
    function automatic logic op_is_signed(input logic [3:0] op);
        return (op <= OP_DIV) && !op[0];
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring unsigned divider core: one quotient bit per step, WIDTH steps per divide.
module muldiv_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quot,
    output logic [WIDTH-1:0] o_rem
);
    logic [WIDTH-1:0] r_rem, r_quot, r_div;
    logic [WIDTH:0]   w_shift, w_trial;

    // Dividend bits shift out of r_quot while quotient bits shift in
    assign w_shift = {r_rem, r_quot[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_div};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
        end else if (i_load) begin
            r_rem  <= '0;
            r_quot <= i_dividend;
            r_div  <= i_divisor;
        end else if (i_step) begin
            r_rem  <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
            r_quot <= {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
        end
    end

    assign o_quot = r_quot;
    assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_done,
    output logic             o_err,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_hi, r_lo, r_mplier;
    logic [2*WIDTH-1:0] r_mcand, r_prod;
    logic               r_b_zero, r_neg_res, r_neg_rem, r_err;
    logic [CW-1:0]      r_cnt;

    logic               w_accept, w_commit, w_sgn, w_long, w_div_step;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_quot, w_rem;
    logic [2*WIDTH-1:0] w_prod, w_fix;

    assign w_sgn      = op_is_signed(i_op);
    assign w_long     = op_is_mul(i_op) || op_is_div(i_op);
    assign w_mag_a    = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mag_b    = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;
    assign w_div_step = (r_state == ST_CALC);

    muldiv_divider #(.WIDTH(WIDTH)) u_div (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_accept),
        .i_step     (w_div_step),
        .i_dividend (w_mag_a),
        .i_divisor  (w_mag_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        o_start_ready = 1'b0;
        o_done        = 1'b0;
        w_accept      = 1'b0;
        w_commit      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_start_ready = 1'b1;
                if (i_start_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_long ? ST_CALC : ST_FINISH;
                end
            end
            ST_CALC: begin
                if (i_flush)              w_state_nxt = ST_IDLE;
                else if (r_cnt == '0)     w_state_nxt = ST_FIXUP;
            end
            ST_FIXUP: begin
                if (i_flush) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_FINISH;
                end
            end
            ST_FINISH: begin
                o_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction and accumulate; r_neg_res is the product or quotient sign
    always_comb begin
        w_prod = r_neg_res ? -r_prod : r_prod;
        w_fix  = w_prod;
        case (r_op)
            OP_MADD, OP_MADDU: w_fix = {r_hi, r_lo} + w_prod;
            OP_MSUB, OP_MSUBU: w_fix = {r_hi, r_lo} - w_prod;
            OP_DIV, OP_DIVU: begin
                if (r_b_zero) w_fix = {r_a, {WIDTH{DIV0_LO_BIT}}};
                else          w_fix = {(r_neg_rem ? -w_rem : w_rem),
                                       (r_neg_res ? -w_quot : w_quot)};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b_zero  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_prod    <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_op      <= i_op;
            r_a       <= i_a;
            r_b_zero  <= (i_b == '0);
            r_neg_res <= w_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_rem <= w_sgn && i_a[WIDTH-1];
            r_mcand   <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplier  <= w_mag_b;
            r_prod    <= '0;
`ifdef MULDIV_FAST_MUL_EN
            r_cnt     <= op_is_mul(i_op) ? '0 : CNT_LAST;
`else
            r_cnt     <= CNT_LAST;
`endif
            r_err     <= 1'b0;
            case (i_op)
                OP_MTHI: r_hi  <= i_a;
                OP_MTLO: r_lo  <= i_a;
                default: r_err <= (i_op >= OP_ILLEGAL_MIN);
            endcase
        end else if (r_state == ST_CALC) begin
            r_cnt <= r_cnt - CW'(1);
`ifdef MULDIV_FAST_MUL_EN
            if (op_is_mul(r_op)) r_prod <= r_mcand * {{WIDTH{1'b0}}, r_mplier};
`else
            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
`endif
        end else if (w_commit) begin
            r_hi  <= w_fix[2*WIDTH-1:WIDTH];
            r_lo  <= w_fix[WIDTH-1:0];
            r_err <= op_is_div(r_op) && r_b_zero;
        end
    end

    assign o_err = r_err;
    assign o_hi  = r_hi;
    assign o_lo  = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO/err, a monitor checks on done.
module tb_muldiv_unit;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT   = 3;
    localparam int FLUSH_DLY = 1;
`else
    localparam int MUL_LAT   = W + 2;
    localparam int FLUSH_DLY = 10;
`endif
    localparam int DIV_LAT = W + 2;

    logic         clk = 1'b0, rst_n = 1'b0, start_valid = 1'b0, flush = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         start_ready, done, err;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [2*W:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_op          (op),
        .i_a           (a),
        .i_b           (b),
        .i_flush       (flush),
        .o_done        (done),
        .o_err         (err),
        .o_hi          (hi),
        .o_lo          (lo)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2*W:0] e;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                e = exp_q.pop_front();
                chk("hi", hi, e[2*W:W+1]);
                chk("lo", lo, e[W:1]);
                chk("err", W'(err), W'(e[0]));
            end
        end
    end

    task automatic do_op(input string name, input logic [3:0] o, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input logic [W-1:0] eh, input logic [W-1:0] el,
                         input logic ee, input int lat, input logic fl);
        int n;
        @(negedge clk);
        chk({name, "_ready"}, W'(start_ready), W'(1));
        start_valid = 1'b1; op = o; a = ia; b = ib; flush = fl;
        exp_q.push_back({eh, el, ee});
        @(posedge clk);
        #1;
        start_valid = 1'b0; flush = 1'b0; a = '1; b = '1; op = 4'd15;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
        chk({name, "_lat"}, W'(n), W'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  saw_done;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_ready", W'(start_ready), W'(1));
        chk("rst_done", W'(done), W'(0));
        chk("rst_err", W'(err), W'(0));
        rst_n = 1'b1;

        do_op("mult",   4'd0, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MUL_LAT, 1'b0);
        do_op("multu",  4'd1, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 1'b0, MUL_LAT, 1'b0);
        do_op("mthi",   4'd8, 32'd0,  32'd0,  32'h0, 32'hFFFFFFFA, 1'b0, 1, 1'b0);
        do_op("mtlo",   4'd9, 32'd10, 32'd0,  32'h0, 32'd10, 1'b0, 1, 1'b0);
        do_op("madd",   4'd2, 32'd5,  32'd6,  32'h0, 32'd40, 1'b0, MUL_LAT, 1'b0);
        do_op("msubu",  4'd5, 32'd1,  32'd41, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, MUL_LAT, 1'b0);
        do_op("div_n",  4'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b0);
        do_op("divu",   4'd7, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, DIV_LAT, 1'b0);
        do_op("div_bn", 4'd6, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b0);
        do_op("div0",   4'd7, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, DIV_LAT, 1'b0);
        do_op("divmin", 4'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, DIV_LAT, 1'b0);
        do_op("msub",   4'd4, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h80000006, 1'b0, MUL_LAT, 1'b0);
        do_op("multu_max", 4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT, 1'b0);

        // Flush mid-multiply: no done, HI/LO unchanged, idle next cycle
        @(negedge clk);
        start_valid = 1'b1; op = 4'd0; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (FLUSH_DLY) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_ready", W'(start_ready), W'(1));
        chk("flush_hi", hi, 32'hFFFFFFFE);
        chk("flush_lo", lo, 32'h00000001);
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        chk("flush_no_done", W'(saw_done), W'(0));
        do_op("multu_after_flush", 4'd1, 32'd2, 32'd2, 32'h0, 32'd4, 1'b0, MUL_LAT, 1'b0);
        do_op("mthi_pre_rst", 4'd8, 32'hAAAA, 32'd0, 32'hAAAA, 32'd4, 1'b0, 1, 1'b0);

        // Reset in the middle of a divide
        @(negedge clk);
        start_valid = 1'b1; op = 4'd6; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        chk("midrst_ready", W'(start_ready), W'(1));
        chk("midrst_done", W'(done), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        do_op("mthi2",   4'd8,  32'h55, 32'd0, 32'h55, 32'h0, 1'b0, 1, 1'b0);
        do_op("illegal", 4'd12, 32'h99, 32'h77, 32'h55, 32'h0, 1'b1, 1, 1'b0);
        do_op("mtlo_flush_idle", 4'd9, 32'd7, 32'd0, 32'h55, 32'd7, 1'b0, 1, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It runs the long-latency integer operations that the single-cycle ALU cannot finish in one cycle: signed and unsigned multiply, multiply-accumulate and multiply-subtract, and divide, plus direct HI/LO writes. It sits beside the ALU in the execute stage. The core stalls on `start_ready` and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_valid`  in  1  request presented.
- `start_ready`  out  1  unit idle; request accepted when `start_valid && start_ready`.
- `op`  in  4  operation, encoded as in the shared package.
- `a`, `b`  in  WIDTH  operands (rs, rt).
- `flush`  in  1  synchronous abort of the in-flight operation.
- `done`  out  1  one-cycle pulse when HI/LO have been updated.
- `err`  out  1  valid with `done`; set for an illegal op or divide-by-zero.
- `hi`, `lo`  out  WIDTH  architectural HI/LO, registered.

## Operation
- Op codes: 0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU, 8 MTHI, 9 MTLO. Codes 10–15 are illegal.
- Operands are latched on accept; `a`/`b` may change afterwards.
- Multiply: p = a*b, signed or unsigned per op, full 2*WIDTH bits.
  - MULT/MULTU: {hi,lo} = p.
  - MADD/MADDU: {hi,lo} += p.
  - MSUB/MSUBU: {hi,lo} -= p.
  - All multiply results are modulo 2^(2*WIDTH). No overflow flag.
- Divide: lo = quotient, hi = remainder.
  - Signed divide truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1: lo = MIN, hi = 0, err = 0.
  - b == 0: hi = a, lo = all ones, err = 1.
- MTHI/MTLO: write a into hi or lo. The other register is unchanged.
- Illegal op: accepted, HI/LO unchanged, done with err = 1.
- FSM states:
  - IDLE: start_ready = 1.
  - On accept, MTHI/MTLO/illegal go to FINISH; multiply/divide go to CALC.
  - CALC: iterative, one bit per cycle, runs WIDTH cycles, then goes to FIXUP.
  - FIXUP: sign correction plus accumulate into {hi,lo}, then goes to FINISH.
  - FINISH: done = 1, then goes to IDLE.
- Signed operations iterate on magnitudes; sign correction happens in FIXUP.
- `flush` in CALC or FIXUP: return to IDLE next cycle, HI/LO unchanged, no done. `flush` in IDLE or FINISH has no effect.

## Timing
- Reset values: hi = 0, lo = 0, done = 0, err = 0, start_ready = 1, state IDLE.
- Reset mid-operation aborts immediately.
- Latency from accept edge to done cycle:
  - Multiply and divide: WIDTH+2 cycles.
  - MTHI/MTLO/illegal: 1 cycle.
- hi/lo take their new values in the done cycle.
- start_ready is low from the cycle after accept through the done cycle. A new request may be accepted in the cycle after done.
- hi/lo are stable while busy; they show the pre-operation values.
- `flush` and `start_valid` in the same IDLE cycle: the request is accepted (flush is ignored in IDLE).

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiply ops use a single-cycle combinational WIDTH×WIDTH multiplier: CALC lasts 1 cycle and multiply latency is 3.
  - Divide is unchanged.
- Macro undefined: shift-add multiplier with WIDTH-cycle CALC.
- Ports and results are identical in both builds.

## Structure
- Package `muldiv_pkg`: op-code constants, FSM state enum, illegal-op range, and the divide-by-zero LO pattern.
- Sub-module `muldiv_divider`: restoring unsigned divider core with load/step/quotient/remainder. The multiplier datapath and FSM stay in the top module.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, err=0. MULTU with the same operands -> hi=0x2, lo=0xFFFFFFFA.
- MTHI 0, MTLO 10, then MADD a=5, b=6 -> lo=40, hi=0. Then MSUBU a=1, b=41 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 -> lo=3, hi=1.
- DIVU a=0x1234, b=0 -> hi=0x1234, lo=0xFFFFFFFF, err=1. DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0, err=0.
- Start MULT 3×4, assert flush 10 cycles later -> no done, hi/lo keep prior values, start_ready high the next cycle. A following MULTU 2×2 -> lo=4.
- Assert rst_n low mid-DIV -> hi=lo=0 immediately, start_ready=1. Op 12 -> done 1 cycle after accept, err=1, hi/lo unchanged.
